// File: rtl/esc_quad_pwm_if.sv
// esc_quad_pwm_if: speed command bus from the flight controller to the ESC PWM block.
// The controller side drives the bus (master); the PWM block samples it (slave).
interface esc_quad_pwm_if;
   logic        wrt;
   logic [10:0] frnt_spd;
   logic [10:0] bck_spd;
   logic [10:0] lft_spd;
   logic [10:0] rght_spd;

   modport master (output wrt, frnt_spd, bck_spd, lft_spd, rght_spd);
   modport slave  (input  wrt, frnt_spd, bck_spd, lft_spd, rght_spd);
endinterface

// File: rtl/esc_quad_pwm.sv
// esc_quad_pwm: drives four ESC PWM lines at a fixed frame rate of 2**PERIOD_W clocks.
// Speeds written on the command bus are double-buffered and only become active at a
// frame boundary, so a pulse in flight is never cut short.
// Optional feature: define ESC_WDOG_EN to enable the link-loss watchdog, which falls
// back to MIN_PULSE after WDOG_FRAMES frames without a write.
module esc_quad_pwm #(
   parameter int PERIOD_W    = 20,
   parameter int MIN_PULSE   = 6250,
   parameter int SPD_SCALE   = 3,
   parameter int WDOG_FRAMES = 8
) (
   input  logic          clk,
   input  logic          rst,
   esc_quad_pwm_if.slave cmd,
   output logic          frnt_pwm,
   output logic          bck_pwm,
   output logic          lft_pwm,
   output logic          rght_pwm,
   output logic          frame_strt,
   output logic          wdog_trip
);

   // Widths reach 12391 with default parameters; 16 bits leaves headroom.
   localparam int WID_W = 16;
   localparam int CMP_W = (PERIOD_W > WID_W) ? PERIOD_W : WID_W;
   localparam logic [WID_W-1:0] MIN_WID = WID_W'(MIN_PULSE);

   // Pulse width for one speed value: unsigned, no saturation.
   function automatic logic [WID_W-1:0] spd2wid(input logic [10:0] spd);
      return MIN_WID + WID_W'(SPD_SCALE) * {5'd0, spd};
   endfunction

   logic [PERIOD_W-1:0]    cnt_r;
   logic [3:0][10:0]       spd_s;
   logic [3:0][10:0]       shd_r;
   logic [3:0][10:0]       ld_spd_s;
   logic                   pend_r;
   logic [3:0][WID_W-1:0]  wid_r;
   logic [3:0]             pwm_r;
   logic                   fstrt_r;
   logic                   last_s;
   logic                   load_s;
   logic                   trip_s;

   // Channel order: 0 front, 1 back, 2 left, 3 right.
   assign spd_s = {cmd.rght_spd, cmd.lft_spd, cmd.bck_spd, cmd.frnt_spd};

   // Frame boundary decode; a write in the last cycle bypasses the shadow registers.
   always_comb begin
      last_s = (cnt_r == {PERIOD_W{1'b1}});
      load_s = last_s && (pend_r || cmd.wrt);
      if (cmd.wrt) begin
         ld_spd_s = spd_s;
      end else begin
         ld_spd_s = shd_r;
      end
   end

   // Free-running frame counter, wraps naturally at 2**PERIOD_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {PERIOD_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + PERIOD_W'(1);
      end
   end

`ifdef ESC_WDOG_EN
   localparam int FC_W = $clog2(WDOG_FRAMES + 1);

   logic [FC_W-1:0] fcnt_r;
   logic            wdog_r;

   // Trip when this boundary completes WDOG_FRAMES loads in a row with no write seen.
   // pend_r doubles as "a write arrived since the previous load".
   always_comb begin
      if (last_s && !pend_r && !cmd.wrt && (fcnt_r >= FC_W'(WDOG_FRAMES - 1))) begin
         trip_s = 1'b1;
      end else begin
         trip_s = 1'b0;
      end
   end

   // Count silent frame loads; any write restarts the count, saturates once tripped.
   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt_r <= {FC_W{1'b0}};
      end else if (cmd.wrt) begin
         fcnt_r <= {FC_W{1'b0}};
      end else if (last_s) begin
         if (pend_r) begin
            fcnt_r <= {FC_W{1'b0}};
         end else if (trip_s) begin
            fcnt_r <= FC_W'(WDOG_FRAMES);
         end else begin
            fcnt_r <= fcnt_r + FC_W'(1);
         end
      end
   end

   // Trip flag: set by the watchdog, released by the next write.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_r <= 1'b0;
      end else if (cmd.wrt) begin
         wdog_r <= 1'b0;
      end else if (trip_s) begin
         wdog_r <= 1'b1;
      end
   end

   assign wdog_trip = wdog_r;
`else
   logic unused_wdog_s;

   assign unused_wdog_s = (WDOG_FRAMES != 0);
   assign trip_s        = 1'b0;
   assign wdog_trip     = 1'b0;
`endif

   // Double buffer: shadow captures writes, active widths change only at the boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         shd_r  <= '0;
         pend_r <= 1'b0;
         wid_r  <= {4{MIN_WID}};
      end else if (trip_s) begin
         shd_r  <= '0;
         pend_r <= 1'b0;
         wid_r  <= {4{MIN_WID}};
      end else if (load_s) begin
         shd_r  <= ld_spd_s;
         pend_r <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            wid_r[i] <= spd2wid(ld_spd_s[i]);
         end
      end else if (cmd.wrt) begin
         shd_r  <= spd_s;
         pend_r <= 1'b1;
      end
   end

   // Registered pulse outputs and frame marker, one cycle behind the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_r   <= 4'b0000;
         fstrt_r <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            pwm_r[i] <= (CMP_W'(cnt_r) < CMP_W'(wid_r[i]));
         end
         fstrt_r <= (cnt_r == {PERIOD_W{1'b0}});
      end
   end

   assign frnt_pwm   = pwm_r[0];
   assign bck_pwm    = pwm_r[1];
   assign lft_pwm    = pwm_r[2];
   assign rght_pwm   = pwm_r[3];
   assign frame_strt = fstrt_r;

endmodule

// File: tb/tb_esc_quad_pwm.sv
// tb_esc_quad_pwm: self-checking bench for esc_quad_pwm.
// A 13-bit frame (8192 cycles) still holds the widest pulse of 6241 cycles.
// Define ESC_WDOG_EN to also exercise the watchdog sequence.
module tb_esc_quad_pwm;
   localparam int P_W = 13;
   localparam int F   = 1 << P_W;
   localparam int MIN = 100;
   localparam int SC  = 3;
   localparam int WD  = 4;

   typedef struct {
      int               cyc;
      logic [3:0][10:0] spd;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frame_strt, wdog_trip;

   int  cyc   = 0;
   int  n_chk = 0;
   int  n_err = 0;
   wr_t wq[$];

   esc_quad_pwm_if bus ();

   esc_quad_pwm #(
      .PERIOD_W(P_W), .MIN_PULSE(MIN), .SPD_SCALE(SC), .WDOG_FRAMES(WD)
   ) dut (
      .clk(clk), .rst(rst), .cmd(bus),
      .frnt_pwm(frnt_pwm), .bck_pwm(bck_pwm), .lft_pwm(lft_pwm), .rght_pwm(rght_pwm),
      .frame_strt(frame_strt), .wdog_trip(wdog_trip)
   );

   always #5 clk = ~clk;

   // Bench cycle index: equals the value the DUT frame counter holds in this cycle.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: width of channel ch in frame k, from the last write sampled before frame k.
   function automatic int exp_width(input int k, input int ch);
      int last = -1;
      int j;
      for (int i = 0; i < wq.size(); i++) begin
         if (wq[i].cyc < k * F) last = i;
      end
      if (last < 0) return MIN;
      j = wq[last].cyc / F;
`ifdef ESC_WDOG_EN
      if ((k - 1 - j) >= WD) return MIN;
`endif
      return MIN + SC * int'(wq[last].spd[ch]);
   endfunction

   function automatic logic [10:0] rs();
      return 11'($urandom_range(2047, 0));
   endfunction

   task automatic do_wrt(input logic [10:0] f, input logic [10:0] b,
                         input logic [10:0] l, input logic [10:0] r);
      wr_t w;
      bus.frnt_spd = f;
      bus.bck_spd  = b;
      bus.lft_spd  = l;
      bus.rght_spd = r;
      bus.wrt      = 1'b1;
      w.cyc = cyc;
      w.spd = {r, l, b, f};
      wq.push_back(w);
      @(negedge clk);
      bus.wrt = 1'b0;
   endtask

   task automatic goto_cyc(input int t);
      int n = 0;
      while (cyc != t && n < 3 * F) begin
         @(negedge clk);
         n++;
      end
      chk("goto_cycle", cyc, t);
   endtask

   // Frame monitor: measures each pulse width and frame marker over one full output frame.
   int   hi[4];
   int   exp_w[4];
   int   fs_n;
   int   fs0;
   int   kf;
   logic win_ok = 1'b0;

   always @(negedge clk) begin
      int idx;
      int pos;
      logic [3:0] p;
      p = {rght_pwm, lft_pwm, bck_pwm, frnt_pwm};
      if (rst) begin
         win_ok = 1'b0;
      end else if (cyc >= 1) begin
         idx = cyc - 1;
         pos = idx % F;
         if (pos == 0) begin
            win_ok = 1'b1;
            kf     = idx / F;
            fs_n   = 0;
            fs0    = int'(frame_strt);
            for (int ch = 0; ch < 4; ch++) begin
               hi[ch]    = 0;
               exp_w[ch] = exp_width(kf, ch);
            end
         end
         if (win_ok) begin
            for (int ch = 0; ch < 4; ch++) hi[ch] += int'(p[ch]);
            fs_n += int'(frame_strt);
            if (pos == F - 1) begin
               for (int ch = 0; ch < 4; ch++)
                  chk($sformatf("frame%0d_width_ch%0d", kf, ch), hi[ch], exp_w[ch]);
               chk($sformatf("frame%0d_strt_count", kf), fs_n, 1);
               chk($sformatf("frame%0d_strt_first", kf), fs0, 1);
`ifndef ESC_WDOG_EN
               chk($sformatf("frame%0d_wdog_off", kf), {31'd0, wdog_trip}, 0);
`endif
               win_ok = 1'b0;
            end
         end
      end
   end

   initial begin
      rst          = 1'b1;
      bus.wrt      = 1'b0;
      bus.frnt_spd = 11'd0;
      bus.bck_spd  = 11'd0;
      bus.lft_spd  = 11'd0;
      bus.rght_spd = 11'd0;
      repeat (3) @(negedge clk);
      chk("reset_pwm", {28'd0, rght_pwm, lft_pwm, bck_pwm, frnt_pwm}, 0);
      chk("reset_frame_strt", {31'd0, frame_strt}, 0);
      chk("reset_wdog", {31'd0, wdog_trip}, 0);
      rst = 1'b0;

      // Frame 0 stays at MIN_PULSE; mid-frame write applies to frame 1.
      goto_cyc(3000);
      do_wrt(11'h000, 11'h001, 11'h400, 11'h7FF);

      // Two writes in frame 1: last one wins (front 160 in frame 2).
      goto_cyc(F + 1000);
      do_wrt(11'd10, rs(), rs(), rs());
      goto_cyc(F + 2000);
      do_wrt(11'd20, rs(), rs(), rs());

      // Write in the very last cycle of frame 2 lands in frame 3.
      goto_cyc(2 * F + 500);
      do_wrt(rs(), rs(), rs(), rs());
      goto_cyc(3 * F - 1);
      do_wrt(11'd50, rs(), rs(), rs());

      // Random burst of writes in frame 3.
      goto_cyc(3 * F + 100);
      do_wrt(rs(), rs(), rs(), rs());
      goto_cyc(3 * F + 4000);
      do_wrt(rs(), rs(), rs(), rs());
      goto_cyc(3 * F + 8000);
      do_wrt(rs(), rs(), rs(), rs());

      // Pending update, then reset in the middle of a pulse.
      goto_cyc(4 * F + 20);
      do_wrt(rs(), rs(), rs(), rs());
      goto_cyc(4 * F + 50);
      chk("pulse_before_reset", {31'd0, frnt_pwm}, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("pwm_after_reset", {28'd0, rght_pwm, lft_pwm, bck_pwm, frnt_pwm}, 0);
      chk("strt_after_reset", {31'd0, frame_strt}, 0);
      wq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // After reset: frame 0 at MIN_PULSE, single write gives front width 400.
      goto_cyc(500);
      do_wrt(11'd100, rs(), rs(), rs());
`ifdef ESC_WDOG_EN
      goto_cyc(4 * F + 100);
      chk("wdog_before_trip", {31'd0, wdog_trip}, 0);
      goto_cyc(5 * F + 100);
      chk("wdog_tripped", {31'd0, wdog_trip}, 1);
      do_wrt(rs(), rs(), rs(), rs());
      chk("wdog_cleared", {31'd0, wdog_trip}, 0);
      goto_cyc(7 * F + 10);
`else
      goto_cyc(2 * F + 10);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
